// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared types and widths for the writeback stage
package writeback_stage_pkg;
  localparam int WB_DATA_W = 64;
  localparam int WB_REG_W  = 4;
  typedef enum logic [1:0] {EMPTY, COMMIT, STORE_WAIT, HALTED} wb_state_t;
  typedef struct packed {
    logic                 kill;
    logic [WB_DATA_W-1:0] alu;
    logic [WB_DATA_W-1:0] special;
    logic [WB_REG_W-1:0]  dest;
    logic                 dest_v;
    logic [WB_REG_W-1:0]  dest_s;
    logic                 dest_s_v;
    logic                 mem;
    logic [WB_DATA_W-1:0] addr;
    logic [WB_DATA_W-1:0] rip;
    logic [WB_DATA_W-1:0] rflags;
  } wb_entry_t;
  function automatic wb_state_t entry_state(input logic mem);
    return mem ? STORE_WAIT : COMMIT;
  endfunction
endpackage

// File: rtl/writeback_stage.sv
// writeback_stage: latches one executed instruction and commits it to the RF,
// rflags or memory, stalling Execute while a store waits and halting after a kill.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W  = WB_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic              killIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] aluResultSpecialIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  input  logic [REG_W-1:0]  destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [DATA_W-1:0] memoryAddressDestIn,
  input  logic [DATA_W-1:0] currentRipIn,
  input  logic [DATA_W-1:0] rflagsIn,
  input  logic              storeAckIn,
  output logic              regWr0EnOut,
  output logic [REG_W-1:0]  regWr0AddrOut,
  output logic [DATA_W-1:0] regWr0DataOut,
  output logic              regWr1EnOut,
  output logic [REG_W-1:0]  regWr1AddrOut,
  output logic [DATA_W-1:0] regWr1DataOut,
  output logic              rflagsWrEnOut,
  output logic [DATA_W-1:0] rflagsOut,
  output logic              storeReqOut,
  output logic [DATA_W-1:0] storeAddrOut,
  output logic [DATA_W-1:0] storeDataOut,
  output logic              wbStallOut,
  output logic              haltOut,
  output logic [DATA_W-1:0] retiredCountOut,
  output logic [DATA_W-1:0] retiredRipOut
);
  wb_state_t         state_q, state_d, follow;
  wb_entry_t         entry_q, entry_d;
  logic [DATA_W-1:0] count_q, count_d, rip_q, rip_d;
  logic              commit, accept, wr0_en, wr1_en, store_req;
  always_comb begin
    commit          = state_q == COMMIT || (state_q == STORE_WAIT && storeAckIn);
    store_req       = state_q == STORE_WAIT;
    wr0_en          = commit & entry_q.dest_v & ~entry_q.mem;
    // primary port wins when both ports target the same register
    wr1_en          = commit & entry_q.dest_s_v & ~(wr0_en && entry_q.dest_s == entry_q.dest);
    regWr0EnOut     = wr0_en;
    regWr0AddrOut   = wr0_en ? entry_q.dest : '0;
    regWr0DataOut   = wr0_en ? entry_q.alu : '0;
    regWr1EnOut     = wr1_en;
    regWr1AddrOut   = wr1_en ? entry_q.dest_s : '0;
    regWr1DataOut   = wr1_en ? entry_q.special : '0;
    rflagsWrEnOut   = commit;
    rflagsOut       = commit ? entry_q.rflags : '0;
    storeReqOut     = store_req;
    storeAddrOut    = store_req ? entry_q.addr : '0;
    storeDataOut    = store_req ? entry_q.alu : '0;
    wbStallOut      = state_q == HALTED || (store_req && !storeAckIn) || (state_q == COMMIT && entry_q.kill);
    haltOut         = state_q == HALTED;
    retiredCountOut = count_q + DATA_W'(commit);
    retiredRipOut   = commit ? entry_q.rip : rip_q;
  end
  always_comb begin
    accept  = validIn & ~wbStallOut;
    entry_d = accept ? wb_entry_t'{
      kill: killIn, alu: aluResultIn, special: aluResultSpecialIn,
      dest: destRegIn, dest_v: destRegValidIn,
      dest_s: destRegSpecialIn, dest_s_v: destRegSpecialValidIn,
      mem: isMemoryAccessDestIn, addr: memoryAddressDestIn,
      rip: currentRipIn, rflags: rflagsIn} : entry_q;
    follow  = entry_q.kill ? HALTED : accept ? entry_state(isMemoryAccessDestIn) : EMPTY;
    state_d = state_q == EMPTY ? (accept ? entry_state(isMemoryAccessDestIn) : EMPTY)
            : commit ? follow : state_q;
    count_d = retiredCountOut;
    rip_d   = retiredRipOut;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      entry_q <= '0;
      count_q <= '0;
      rip_q   <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      rip_q   <= rip_d;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage
module tb_writeback_stage;
  logic clk = 0, reset = 1;
  logic validIn = 0, killIn = 0, destRegValidIn = 0, destRegSpecialValidIn = 0;
  logic isMemoryAccessDestIn = 0, storeAckIn = 0;
  logic [63:0] aluResultIn = 0, aluResultSpecialIn = 0, memoryAddressDestIn = 0;
  logic [63:0] currentRipIn = 0, rflagsIn = 0;
  logic [3:0] destRegIn = 0, destRegSpecialIn = 0;
  logic regWr0EnOut, regWr1EnOut, rflagsWrEnOut, storeReqOut, wbStallOut, haltOut;
  logic [3:0] regWr0AddrOut, regWr1AddrOut;
  logic [63:0] regWr0DataOut, regWr1DataOut, rflagsOut, storeAddrOut, storeDataOut;
  logic [63:0] retiredCountOut, retiredRipOut;
  int checks = 0, failures = 0;
  writeback_stage dut (
    .clk(clk), .reset(reset), .validIn(validIn), .killIn(killIn),
    .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
    .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
    .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
    .currentRipIn(currentRipIn), .rflagsIn(rflagsIn), .storeAckIn(storeAckIn),
    .regWr0EnOut(regWr0EnOut), .regWr0AddrOut(regWr0AddrOut), .regWr0DataOut(regWr0DataOut),
    .regWr1EnOut(regWr1EnOut), .regWr1AddrOut(regWr1AddrOut), .regWr1DataOut(regWr1DataOut),
    .rflagsWrEnOut(rflagsWrEnOut), .rflagsOut(rflagsOut),
    .storeReqOut(storeReqOut), .storeAddrOut(storeAddrOut), .storeDataOut(storeDataOut),
    .wbStallOut(wbStallOut), .haltOut(haltOut),
    .retiredCountOut(retiredCountOut), .retiredRipOut(retiredRipOut)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic k, input logic [63:0] alu, input logic [63:0] sp,
                       input logic [3:0] d, input logic dv, input logic [3:0] ds, input logic dsv,
                       input logic m, input logic [63:0] a, input logic [63:0] rip, input logic [63:0] fl);
    validIn = 1; killIn = k; aluResultIn = alu; aluResultSpecialIn = sp;
    destRegIn = d; destRegValidIn = dv; destRegSpecialIn = ds; destRegSpecialValidIn = dsv;
    isMemoryAccessDestIn = m; memoryAddressDestIn = a; currentRipIn = rip; rflagsIn = fl;
    #1;
  endtask
  task automatic idle();
    validIn = 0; killIn = 0; destRegValidIn = 0; destRegSpecialValidIn = 0; isMemoryAccessDestIn = 0;
    #1;
  endtask
  initial begin
    step(); step();
    chk("rst_wr0en", regWr0EnOut, 0);
    chk("rst_count", retiredCountOut, 0);
    chk("rst_stall", wbStallOut, 0);
    chk("rst_halt", haltOut, 0);
    chk("rst_storereq", storeReqOut, 0);
    reset = 0;
    // single ADD
    drive(0, 64'h5, 0, 4'd3, 1, 0, 0, 0, 0, 64'h100, 64'h2);
    chk("add_accept_stall", wbStallOut, 0);
    step(); idle();
    chk("add_wr0en", regWr0EnOut, 1);
    chk("add_wr0addr", regWr0AddrOut, 3);
    chk("add_wr0data", regWr0DataOut, 64'h5);
    chk("add_wr1en", regWr1EnOut, 0);
    chk("add_flagsen", rflagsWrEnOut, 1);
    chk("add_flags", rflagsOut, 64'h2);
    chk("add_count", retiredCountOut, 1);
    chk("add_rip", retiredRipOut, 64'h100);
    step();
    chk("add_empty_wr0en", regWr0EnOut, 0);
    chk("add_empty_flagsen", rflagsWrEnOut, 0);
    chk("add_empty_count", retiredCountOut, 1);
    chk("add_empty_rip", retiredRipOut, 64'h100);
    // back-to-back register ops
    for (int i = 0; i < 4; i++) begin
      drive(0, 64'h10 + 64'(i), 0, 4'(4 + i), 1, 0, 0, 0, 0, 64'h110 + 64'(i), 0);
      chk("b2b_stall", wbStallOut, 0);
      if (i > 0) begin
        chk("b2b_wr0en", regWr0EnOut, 1);
        chk("b2b_wr0addr", regWr0AddrOut, 64'(3 + i));
        chk("b2b_wr0data", regWr0DataOut, 64'h10 + 64'(i - 1));
      end
      step();
    end
    idle();
    chk("b2b_last_wr0addr", regWr0AddrOut, 7);
    chk("b2b_last_wr0data", regWr0DataOut, 64'h13);
    chk("b2b_count", retiredCountOut, 5);
    step();
    chk("b2b_empty_wr0en", regWr0EnOut, 0);
    // MUL with distinct and equal destinations
    drive(0, 64'h1, 64'hFF, 4'd0, 1, 4'd2, 1, 0, 0, 64'h120, 0);
    step();
    chk("mul_wr0en", regWr0EnOut, 1);
    chk("mul_wr0addr", regWr0AddrOut, 0);
    chk("mul_wr0data", regWr0DataOut, 64'h1);
    chk("mul_wr1en", regWr1EnOut, 1);
    chk("mul_wr1addr", regWr1AddrOut, 2);
    chk("mul_wr1data", regWr1DataOut, 64'hFF);
    drive(0, 64'h1, 64'hFF, 4'd2, 1, 4'd2, 1, 0, 0, 64'h124, 0);
    chk("mul2_accept_stall", wbStallOut, 0);
    step(); idle();
    chk("mulsame_wr0en", regWr0EnOut, 1);
    chk("mulsame_wr0addr", regWr0AddrOut, 2);
    chk("mulsame_wr1en", regWr1EnOut, 0);
    chk("mulsame_count", retiredCountOut, 7);
    step();
    // store with delayed ack; a new op waits until the ack cycle
    drive(0, 64'hAB, 0, 0, 0, 0, 0, 1, 64'h1000, 64'h200, 64'h46);
    step();
    drive(0, 64'h77, 0, 4'd7, 1, 0, 0, 0, 0, 64'h204, 0);
    for (int i = 0; i < 3; i++) begin
      chk("st_req", storeReqOut, 1);
      chk("st_addr", storeAddrOut, 64'h1000);
      chk("st_data", storeDataOut, 64'hAB);
      chk("st_stall", wbStallOut, 1);
      chk("st_wr0en", regWr0EnOut, 0);
      chk("st_flagsen", rflagsWrEnOut, 0);
      step();
    end
    storeAckIn = 1; #1;
    chk("st_ack_req", storeReqOut, 1);
    chk("st_ack_stall", wbStallOut, 0);
    chk("st_ack_wr0en", regWr0EnOut, 0);
    chk("st_ack_flagsen", rflagsWrEnOut, 1);
    chk("st_ack_flags", rflagsOut, 64'h46);
    chk("st_ack_count", retiredCountOut, 8);
    chk("st_ack_rip", retiredRipOut, 64'h200);
    step(); storeAckIn = 0; idle();
    chk("st_next_req", storeReqOut, 0);
    chk("st_next_wr0addr", regWr0AddrOut, 7);
    chk("st_next_wr0data", regWr0DataOut, 64'h77);
    chk("st_next_count", retiredCountOut, 9);
    step();
    // kill
    drive(1, 64'h99, 0, 4'd1, 1, 0, 0, 0, 0, 64'h300, 0);
    step();
    drive(0, 64'h55, 0, 4'd5, 1, 0, 0, 0, 0, 64'h304, 0);
    chk("kill_wr0en", regWr0EnOut, 1);
    chk("kill_wr0data", regWr0DataOut, 64'h99);
    chk("kill_stall", wbStallOut, 1);
    chk("kill_halt", haltOut, 0);
    chk("kill_count", retiredCountOut, 10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_halt", haltOut, 1);
      chk("halt_stall", wbStallOut, 1);
      chk("halt_wr0en", regWr0EnOut, 0);
      chk("halt_flagsen", rflagsWrEnOut, 0);
      chk("halt_count", retiredCountOut, 10);
    end
    idle();
    // reset out of HALTED, then asynchronous reset during a store wait
    reset = 1; #1;
    chk("rst2_halt", haltOut, 0);
    step(); reset = 0;
    drive(0, 64'hCD, 0, 0, 0, 0, 0, 1, 64'h2000, 64'h400, 0);
    step(); idle();
    chk("rst3_req_before", storeReqOut, 1);
    #2 reset = 1; #1;
    chk("rst3_req", storeReqOut, 0);
    chk("rst3_addr", storeAddrOut, 0);
    chk("rst3_stall", wbStallOut, 0);
    chk("rst3_count", retiredCountOut, 0);
    chk("rst3_rip", retiredRipOut, 0);
    step(); reset = 0;
    step();
    chk("rst3_empty_req", storeReqOut, 0);
    drive(0, 64'h5, 0, 4'd3, 1, 0, 0, 0, 0, 64'h500, 0);
    step(); idle();
    chk("post_rst_wr0en", regWr0EnOut, 1);
    chk("post_rst_count", retiredCountOut, 1);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Directly consumes the Execute stage results: ALU result, special result, destination register codes, memory-destination address and kill.
- Latches one completed instruction per cycle and commits it to the register file through two write ports (primary and special, e.g. RAX/RDX for MUL), to rflags, or to memory via a store handshake.
- Drives wbStallIn back to Execute while a commit is blocked. Holds the machine halted after a kill.

Parameters:
DATA_W, 64, width of result, address, rflags and retire-count buses
REG_W, 4, width of register code

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
validIn  in  1  instruction present (Execute isExecuteSuccessfulOut)
killIn  in  1  instruction terminates program (Execute killOut)
aluResultIn  in  DATA_W  primary result
aluResultSpecialIn  in  DATA_W  special result (upper MUL half)
destRegIn  in  REG_W  primary destination register
destRegValidIn  in  1  primary destination valid
destRegSpecialIn  in  REG_W  special destination register
destRegSpecialValidIn  in  1  special destination valid
isMemoryAccessDestIn  in  1  primary result goes to memory
memoryAddressDestIn  in  DATA_W  store address
currentRipIn  in  DATA_W  RIP of instruction
rflagsIn  in  DATA_W  flags after execution
storeAckIn  in  1  memory accepted store
regWr0EnOut/regWr0AddrOut/regWr0DataOut  out  1/REG_W/DATA_W  primary RF write
regWr1EnOut/regWr1AddrOut/regWr1DataOut  out  1/REG_W/DATA_W  special RF write
rflagsWrEnOut  out  1  rflags write strobe
rflagsOut  out  DATA_W  committed rflags
storeReqOut  out  1  store request
storeAddrOut  out  DATA_W  store address
storeDataOut  out  DATA_W  store data
wbStallOut  out  1  Execute must hold (Execute wbStallIn)
haltOut  out  1  program finished, sticky
retiredCountOut  out  DATA_W  committed instruction count
retiredRipOut  out  DATA_W  RIP of last committed instruction

Behaviour:
Reset:
- All outputs 0. State EMPTY. Latch invalid.
- Asynchronous: an in-flight storeReqOut drops immediately and the pending store is discarded.

Acceptance:
- accept = validIn & !wbStallOut.
- On accept, all inputs are captured into the latch at the clock edge.

States: EMPTY, COMMIT, STORE_WAIT, HALTED.
- EMPTY: no outputs active. accept -> STORE_WAIT if isMemoryAccessDestIn, else COMMIT.
- COMMIT: commit the latched entry this cycle.
  - If latched kill -> HALTED.
  - Else accept -> COMMIT/STORE_WAIT by the new entry's type.
  - Else -> EMPTY.
  - Back-to-back throughput: 1 instruction per cycle.
- STORE_WAIT: storeReqOut=1 with addr = latched address and data = latched aluResult; held stable until storeAckIn.
  - Ack in the same cycle as the request is legal and completes in that cycle.
  - On ack: commit (special write, rflags, count); next state as in COMMIT.
- HALTED: haltOut=1, wbStallOut=1. No RF, rflags or store activity. Leaves only via reset.

Stall:
- wbStallOut = HALTED | (STORE_WAIT & !storeAckIn) | (COMMIT & latched kill).
- Combinational from state, latch and storeAckIn.

Commit cycle:
- regWr0EnOut = destRegValid & !isMemoryAccessDest.
- regWr1EnOut = destRegSpecialValid.
- If both enables are set and the addresses are equal, port 1 is suppressed (primary wins).
- rflagsWrEnOut=1 with rflagsOut = latched rflags.
- retiredCountOut += 1 (wraps modulo 2^DATA_W).
- retiredRipOut = latched RIP.
- Write outputs are combinational from the latch; latency from accept to RF write is exactly 1 cycle.

Other rules:
- A killed instruction with a memory destination performs its store first, then goes to HALTED.
- validIn while wbStallOut=1 is ignored; Execute holds its outputs.

Decomposition:
- Shared package: wb_state_t enum (EMPTY, COMMIT, STORE_WAIT, HALTED), wb_entry_t packed struct holding the latched fields, DATA_W/REG_W constants.
- No sub-module. The latch and FSM live in one always_ff; commit decode lives in one always_comb.

Test Plan:
- Single ADD: validIn, destReg=3, aluResult=0x5 -> next cycle regWr0En=1, addr 3, data 0x5, rflagsWrEn=1, retiredCount=1; then EMPTY.
- Back-to-back: 4 valid register ops on consecutive cycles -> 4 consecutive RF writes, wbStallOut never high, retiredCount=4.
- MUL, dest=0, special=2, result=0x1, special=0xFF -> wr0 (0,0x1) and wr1 (2,0xFF) in the same cycle. Same test with both dest=2 -> only wr0 fires.
- Store: memDest, addr 0x1000, data 0xAB, ack after 3 cycles -> storeReq held 3 cycles with stable addr/data, wbStallOut high, a new validIn is not accepted; the ack cycle commits, and the next instruction is accepted in that same cycle.
- Kill (RET) -> commits, haltOut=1 next cycle and stays set, wbStallOut=1, later validIn causes no writes.
- Reset asserted mid-STORE_WAIT -> storeReqOut drops asynchronously, all outputs 0, retiredCount=0, state EMPTY after release.
